// File: rtl/bn_scheduler.sv
// rtl/bn_scheduler.sv - round-robin scheduler sharing one batch-normalization datapath
// Holds per-requester {factor, addend} config and sequences IDLE -> ISSUE -> CAPTURE.
module bn_scheduler #(
  parameter  int NEURONS      = 4,
  parameter  int WIDTH        = 6,
  parameter  int ADDEND_WIDTH = WIDTH - 2,
  localparam int IDW          = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [IDW-1:0]                 cfg_addr,
  input  logic [3:0]                     cfg_factor,
  input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
  output logic                           cfg_err,
  input  logic [NEURONS-1:0]             req,
  input  logic [NEURONS*WIDTH-1:0]       u_flat,
  input  logic [NEURONS*WIDTH-1:0]       z_flat,
  output logic [NEURONS-1:0]             ack,
  output logic [WIDTH-1:0]               bn_u,
  output logic [WIDTH-1:0]               bn_z,
  output logic [3:0]                     bn_factor,
  output logic signed [ADDEND_WIDTH-1:0] bn_addend,
  input  logic [WIDTH-1:0]               bn_u_out,
  output logic                           result_valid,
  output logic [IDW-1:0]                 result_id,
  output logic [WIDTH-1:0]               result,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  localparam logic [3:0] FACTOR_X1 = 4'b0100;

  state_t                         state;
  logic [IDW-1:0]                 rr_ptr;
  logic [IDW-1:0]                 grant_id;
  logic [3:0]                     factor_mem [NEURONS];
  logic signed [ADDEND_WIDTH-1:0] addend_mem [NEURONS];

  logic           found;
  logic [IDW-1:0] pick;
  logic           addr_ok;
  logic           factor_ok;
  logic           cfg_ok;

  // Round-robin search starting at rr_ptr, wrapping at NEURONS.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NEURONS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NEURONS) idx = idx - NEURONS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // Codes xx11 above x8 are undefined; x8 itself only works without an addend.
  always_comb begin
    addr_ok   = ({{(32-IDW){1'b0}}, cfg_addr} < NEURONS);
    factor_ok = 1'b1;
    if (cfg_factor[1:0] == 2'b11) begin
      if (cfg_factor[3:2] != 2'b00) factor_ok = 1'b0;
      else if (cfg_addend != '0)    factor_ok = 1'b0;
    end
    cfg_ok = addr_ok && factor_ok;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      cfg_err      <= 1'b0;
      ack          <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_id    <= '0;
      bn_u         <= '0;
      bn_z         <= '0;
      bn_factor    <= FACTOR_X1;
      bn_addend    <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        factor_mem[i] <= FACTOR_X1;
        addend_mem[i] <= '0;
      end
    end else begin
      cfg_err      <= 1'b0;
      ack          <= '0;
      result_valid <= 1'b0;

      if (cfg_we) begin
        if (cfg_ok) begin
          factor_mem[cfg_addr] <= cfg_factor;
          addend_mem[cfg_addr] <= cfg_addend;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= pick;
            bn_u      <= u_flat[int'(pick)*WIDTH +: WIDTH];
            bn_z      <= z_flat[int'(pick)*WIDTH +: WIDTH];
            bn_factor <= factor_mem[pick];
            bn_addend <= addend_mem[pick];
            state     <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          result       <= bn_u_out;
          result_id    <= grant_id;
          result_valid <= 1'b1;
          ack          <= NEURONS'(1) << grant_id;
          rr_ptr       <= (int'(grant_id) == NEURONS - 1) ? '0 : grant_id + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_scheduler.sv
// tb/tb_bn_scheduler.sv - directed bench for bn_scheduler
// Shared datapath modelled as bn_u_out = bn_u + bn_z.
module tb_bn_scheduler;

  localparam int N = 4;
  localparam int W = 6;
  localparam int AW = W - 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [3:0]           cfg_factor;
  logic signed [AW-1:0] cfg_addend;
  logic                 cfg_err;
  logic [N-1:0]         req;
  logic [N*W-1:0]       u_flat;
  logic [N*W-1:0]       z_flat;
  logic [N-1:0]         ack;
  logic [W-1:0]         bn_u;
  logic [W-1:0]         bn_z;
  logic [3:0]           bn_factor;
  logic signed [AW-1:0] bn_addend;
  logic [W-1:0]         bn_u_out;
  logic                 result_valid;
  logic [1:0]           result_id;
  logic [W-1:0]         result;
  logic                 busy;

  // Three-requester instance: the only way to present an out-of-range address.
  logic                 cfg_we3;
  logic [1:0]           cfg_addr3;
  logic [3:0]           cfg_factor3;
  logic                 cfg_err3;
  logic [2:0]           ack3;
  logic [W-1:0]         bn_u3, bn_z3, result3;
  logic [3:0]           bn_factor3;
  logic signed [AW-1:0] bn_addend3;
  logic                 result_valid3, busy3;
  logic [1:0]           result_id3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign bn_u_out = bn_u + bn_z;

  bn_scheduler #(.NEURONS(N), .WIDTH(W)) u_dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_factor(cfg_factor),
    .cfg_addend(cfg_addend), .cfg_err(cfg_err),
    .req(req), .u_flat(u_flat), .z_flat(z_flat), .ack(ack),
    .bn_u(bn_u), .bn_z(bn_z), .bn_factor(bn_factor), .bn_addend(bn_addend),
    .bn_u_out(bn_u_out), .result_valid(result_valid), .result_id(result_id),
    .result(result), .busy(busy)
  );

  bn_scheduler #(.NEURONS(3), .WIDTH(W)) u_dut3 (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_factor(cfg_factor3),
    .cfg_addend(AW'(0)), .cfg_err(cfg_err3),
    .req(3'b000), .u_flat({(3*W){1'b0}}), .z_flat({(3*W){1'b0}}), .ack(ack3),
    .bn_u(bn_u3), .bn_z(bn_z3), .bn_factor(bn_factor3), .bn_addend(bn_addend3),
    .bn_u_out(bn_u3), .result_valid(result_valid3), .result_id(result_id3),
    .result(result3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] u, input logic [W-1:0] z);
    u_flat[i*W +: W] = u;
    z_flat[i*W +: W] = z;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [3:0] f,
                           input logic signed [AW-1:0] d, input logic exp_err, input string tag);
    cfg_we = 1'b1; cfg_addr = a; cfg_factor = f; cfg_addend = d;
    tick();
    cfg_we = 1'b0;
    check({tag, "_err"}, cfg_err, exp_err);
    tick();
    check({tag, "_err_clr"}, cfg_err, 1'b0);
  endtask

  // Lanes hold u=i+1, z=2i, so the modelled result is 3i+1.
  task automatic do_op(input int id, input logic [3:0] exp_f, input int exp_a, input string tag);
    req = N'(1) << id;
    tick();
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_factor"}, bn_factor, exp_f);
    check({tag, "_addend"}, bn_addend, exp_a);
    tick();
    check({tag, "_ack_early"}, ack, 0);
    tick();
    check({tag, "_ack"}, ack, N'(1) << id);
    check({tag, "_result"}, result, 3 * id + 1);
    check({tag, "_id"}, result_id, id);
    req = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_factor = '0; cfg_addend = '0;
    req = '0; u_flat = '0; z_flat = '0;
    cfg_we3 = 1'b0; cfg_addr3 = '0; cfg_factor3 = '0;
    for (int i = 0; i < N; i++) set_lane(i, W'(10 + i), W'(20 + i));
    tick(); tick();
    reset = 1'b0;
    check("rst_factor", bn_factor, 4'b0100);
    check("rst_addend", bn_addend, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 0);
    check("rst_valid", result_valid, 1'b0);

    // Single request on lane 2: ack in the 4th cycle counting the request cycle.
    set_lane(2, 6'd5, 6'd3);
    req = 4'b0100;
    tick();
    check("s1_bn_u", bn_u, 5);
    check("s1_bn_z", bn_z, 3);
    check("s1_factor", bn_factor, 4'b0100);
    tick();
    check("s1_ack_c3", ack, 0);
    tick();
    check("s1_ack", ack, 4'b0100);
    check("s1_valid", result_valid, 1'b1);
    check("s1_result", result, 8);
    check("s1_id", result_id, 2);
    req = '0;
    tick();
    check("s1_ack_pulse", ack, 0);
    check("s1_valid_pulse", result_valid, 1'b0);

    // Reset so rr_ptr restarts at 0, then hold all requests.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, W'(i + 1), W'(2 * i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int id;
      id = n % N;
      tick();
      check("rr_ack_off1", ack, 0);
      tick();
      check("rr_ack_off2", ack, 0);
      tick();
      check("rr_ack", ack, N'(1) << id);
      check("rr_valid", result_valid, 1'b1);
      check("rr_id", result_id, id);
      check("rr_result", result, 3 * id + 1);
    end
    req = '0;
    tick();

    // Config rejections and acceptances.
    cfg_write(2'd1, 4'b0111, 4'sd0, 1'b1, "cfg_0111");
    cfg_write(2'd1, 4'b1011, 4'sd0, 1'b1, "cfg_1011");
    cfg_write(2'd1, 4'b1111, 4'sd0, 1'b1, "cfg_1111");
    cfg_write(2'd1, 4'b0011, 4'sd1, 1'b1, "cfg_x8_add");
    cfg_write(2'd3, 4'b0011, 4'sd0, 1'b0, "cfg_x8_ok");
    cfg_write(2'd0, 4'b0000, -4'sd3, 1'b0, "cfg_0000");
    do_op(1, 4'b0100, 0, "cfg_kept1");
    do_op(3, 4'b0011, 0, "cfg_new3");
    do_op(0, 4'b0000, -3, "cfg_new0");

    cfg_we3 = 1'b1; cfg_addr3 = 2'd3; cfg_factor3 = 4'b0101;
    tick();
    cfg_we3 = 1'b0;
    check("cfg_addr_oob", cfg_err3, 1'b1);
    cfg_we3 = 1'b1; cfg_addr3 = 2'd2;
    tick();
    cfg_we3 = 1'b0;
    check("cfg_addr_ok", cfg_err3, 1'b0);

    // Config write to lane 1 while its operation is in CAPTURE.
    req = 4'b0010;
    tick();
    check("inf_factor_old", bn_factor, 4'b0100);
    tick();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_factor = 4'b1100; cfg_addend = -4'sd2;
    tick();
    cfg_we = 1'b0;
    check("inf_ack", ack, 4'b0010);
    check("inf_cfg_err", cfg_err, 1'b0);
    check("inf_factor_stable", bn_factor, 4'b0100);
    tick();
    check("inf_next_factor", bn_factor, 4'b1100);
    check("inf_next_addend", bn_addend, -2);
    req = '0;
    tick(); tick();
    check("inf_next_ack", ack, 4'b0010);
    tick();

    // Reset during CAPTURE aborts the operation.
    req = 4'b0001;
    tick(); tick();
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0;
    check("abort_ack", ack, 0);
    check("abort_valid", result_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_bn_u", bn_u, 0);
    check("abort_factor", bn_factor, 4'b0100);
    check("abort_result", result, 0);
    tick();
    check("abort_ack_late", ack, 0);
    do_op(1, 4'b0100, 0, "abort_cfg1");
    do_op(3, 4'b0100, 0, "abort_cfg3");

    // Request dropped right after grant still completes.
    req = 4'b0001;
    tick();
    req = '0;
    tick(); tick();
    check("drop_ack", ack, 4'b0001);
    check("drop_valid", result_valid, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
